// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, one write port, the issue port and status.
// The issuing side drives addresses, write data and issue; the register file answers.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            busy1;
    logic            busy2;
    logic            ready;

    modport master (
        output ra1, ra2, we, wa, wd, iss_en, iss_rd,
        input  rd1, rd2, busy1, busy2, ready
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, iss_en, iss_rd,
        output rd1, rd2, busy1, busy2, ready
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a pending-write scoreboard.
// After reset, an INIT sweep zeroes one register per cycle before the file accepts traffic.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int            AW       = $clog2(NREG);
    localparam logic [AW:0]   NREG_C   = (AW+1)'(NREG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam bit            BYP      = (BYPASS != 0);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic            ready_q;
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] regs [NREG];

    logic run;
    logic wr_ok;
    logic iss_ok;
    logic fwd1;
    logic fwd2;
    logic vis1;
    logic vis2;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_C);
    endfunction

    function automatic logic target_ok(input logic [AW-1:0] a);
        return (a != '0) && addr_ok(a);
    endfunction

    // Everything visible is masked while in reset or still sweeping.
    assign run    = ready_q & ~rst;
    assign wr_ok  = run & bus.we & target_ok(bus.wa);
    assign iss_ok = run & bus.iss_en & target_ok(bus.iss_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= '0;
            ready_q <= 1'b0;
            busy    <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Issue is applied last so a new producer outranks a completing one.
                    if (wr_ok)
                        busy[bus.wa] <= 1'b0;
                    if (iss_ok)
                        busy[bus.iss_rd] <= 1'b1;
                end
                default: begin
                    state   <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is cleared only by the sweep; reset merely holds it still.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                regs[clr_idx] <= '0;
            else if (wr_ok)
                regs[bus.wa] <= bus.wd;
        end
    end

    assign fwd1 = BYP & wr_ok & (bus.wa == bus.ra1);
    assign fwd2 = BYP & wr_ok & (bus.wa == bus.ra2);
    assign vis1 = run & target_ok(bus.ra1);
    assign vis2 = run & target_ok(bus.ra2);

    assign bus.rd1   = fwd1 ? bus.wd : (vis1 ? regs[bus.ra1] : '0);
    assign bus.rd2   = fwd2 ? bus.wd : (vis2 ? regs[bus.ra2] : '0);
    assign bus.busy1 = vis1 & busy[bus.ra1] & ~fwd1;
    assign bus.busy2 = vis2 & busy[bus.ra2] & ~fwd2;
    assign bus.ready = run;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of every register, in bits.
REQ-002 Parameter NREG, default 32: number of registers; legal range 2..64; AW = ceil(log2(NREG)) is derived, not set.
REQ-003 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads show stored contents only.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 ra1  in  AW  read port 1 address.
REQ-007 ra2  in  AW  read port 2 address.
REQ-008 rd1  out  XLEN  read port 1 data, combinational.
REQ-009 rd2  out  XLEN  read port 2 data, combinational.
REQ-010 we  in  1  write enable.
REQ-011 wa  in  AW  write address.
REQ-012 wd  in  XLEN  write data.
REQ-013 iss_en  in  1  instruction issue; marks register iss_rd as pending.
REQ-014 iss_rd  in  AW  destination register of the issued instruction.
REQ-015 busy1  out  1  pending-write flag for ra1, combinational.
REQ-016 busy2  out  1  pending-write flag for ra2, combinational.
REQ-017 ready  out  1  high when the block accepts writes and issues.

Function
REQ-018 The block SHALL have two states, INIT and RUN, plus an AW-bit clear index clr_idx.
REQ-019 In INIT the block SHALL write zero to register[clr_idx] each cycle and increment clr_idx.
REQ-020 INIT SHALL move to RUN on the edge where clr_idx == NREG-1; INIT therefore lasts exactly NREG cycles after rst deasserts.
REQ-021 ready SHALL be 1 only in RUN.
REQ-022 In INIT, we and iss_en SHALL be ignored; rd1, rd2, busy1 and busy2 SHALL read 0.
REQ-023 In RUN, when we=1, wa!=0 and wa<NREG, register[wa] SHALL take wd at the clock edge.
REQ-024 Writes to address 0 or to an address >= NREG SHALL be discarded.
REQ-025 Register 0 SHALL always read 0.
REQ-026 Reads from an address >= NREG SHALL return 0.
REQ-027 When BYPASS=1 and we=1 with wa==raN, wa!=0 and wa<NREG, rdN SHALL equal wd in the same cycle; otherwise rdN SHALL equal register[raN].
REQ-028 The scoreboard SHALL be an NREG-bit vector busy[]; busy[0] SHALL be constantly 0.
REQ-029 In RUN, iss_en=1 with iss_rd!=0 and iss_rd<NREG SHALL set busy[iss_rd] at the edge.
REQ-030 In RUN, a legal write SHALL clear busy[wa] at the edge.
REQ-031 When the issue and the write name the same index in one cycle, the set SHALL win and busy stays 1 (a new producer replaces the old one).
REQ-032 busyN SHALL equal busy[raN], except that when BYPASS=1 and a legal write to raN occurs in the same cycle, busyN SHALL read 0.
REQ-033 With both read ports on the same address, outputs SHALL be identical.

Reset
REQ-034 rst=1 at an edge SHALL force INIT, clr_idx=0, all busy bits 0 and ready=0, from any state, including mid-INIT.
REQ-035 Register contents SHALL be zeroed only by the INIT sweep, never by rst itself.
REQ-036 While rst=1, all outputs SHALL read 0.

Verification
REQ-037 Deassert rst, count cycles: ready rises after exactly NREG (32) cycles, and every register reads 0.
REQ-038 In RUN: write wa=5, wd=0xDEADBEEF with ra1=5. With BYPASS=1, rd1=0xDEADBEEF in the same cycle; with BYPASS=0, rd1=0 in that cycle and 0xDEADBEEF in the next.
REQ-039 Write wa=0, wd=0xFFFFFFFF; then ra1=0 gives rd1=0, and busy1 stays 0 after iss_en with iss_rd=0.
REQ-040 iss_en, iss_rd=7: busy[7]=1 next cycle. A write to 7 alone clears it. A write to 7 together with iss_rd=7 leaves busy[7]=1.
REQ-041 Assert rst at INIT cycle 10 (NREG=32): ready stays 0, and the sweep restarts at index 0, lasting a full 32 cycles.
REQ-042 With NREG=24: a write to wa=30 is discarded, ra1=30 gives rd1=0, and INIT lasts 24 cycles.
